// File: rtl/cluster_unpacker_if.sv
// Frame-in / strip-map-out bus of the cluster unpacker.
// master drives the packed frame, slave (the unpacker) returns the rebuilt map.
interface cluster_unpacker_if #(
    parameter int N_CLUSTERS = 8,
    parameter int CLW        = 14,
    parameter int MXSBITS    = 1536
);
    logic [N_CLUSTERS*CLW-1:0] clusters_i;
    logic                      clusters_valid_i;
    logic                      overflow_i;
    logic                      ready_o;
    logic [MXSBITS-1:0]        sbits_o;
    logic                      sbits_valid_o;
    logic                      overflow_o;
    logic [3:0]                n_clusters_o;
    logic                      overlap_o;

    modport master (
        output clusters_i, clusters_valid_i, overflow_i,
        input  ready_o, sbits_o, sbits_valid_o, overflow_o, n_clusters_o, overlap_o
    );

    modport slave (
        input  clusters_i, clusters_valid_i, overflow_i,
        output ready_o, sbits_o, sbits_valid_o, overflow_o, n_clusters_o, overlap_o
    );
endinterface

// File: rtl/cluster_unpacker.sv
// Rebuilds the S-bit strip map from one frame of packed clusters, one cluster per clock.
// Define CLUSTER_UNPACKER_OVERLAP_CHECK_EN to flag frames whose clusters overlap.
module cluster_unpacker #(
    parameter int N_CLUSTERS = 8,
    parameter int MXADRB     = 11,
    parameter int MXCNTB     = 3,
    parameter int MXSBITS    = 1536
) (
    input logic               clock,
    input logic               reset_n,
    cluster_unpacker_if.slave bus
);
    localparam int CLW  = MXADRB + MXCNTB;
    localparam int IDXW = (N_CLUSTERS > 1) ? $clog2(N_CLUSTERS) : 1;
    localparam int MAXW = 2 ** MXCNTB;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t                         state_q, state_d;
    logic [N_CLUSTERS-1:0][CLW-1:0] frame_q;
    logic                           ovf_q;
    logic [IDXW-1:0]                idx_q;
    logic [3:0]                     cnt_q;
    logic [MXSBITS-1:0]             map_q;
    logic                           accept;

    logic [CLW-1:0]     cl;
    logic [MXADRB-1:0]  adr;
    logic [MXCNTB-1:0]  size;
    logic               slot_hit;
    logic [MXSBITS-1:0] base, mask;

    // Current slot decode; the left shift naturally clips strips past the map end.
    assign cl       = frame_q[idx_q];
    assign adr      = cl[MXADRB-1:0];
    assign size     = cl[CLW-1:MXADRB];
    assign slot_hit = 32'(adr) < MXSBITS;

    always_comb begin
        base = '0;
        for (int i = 0; i < MAXW; i++)
            base[i] = (i <= int'(size));
    end

    assign mask = base << adr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (bus.clusters_valid_i) begin
                accept  = 1'b1;
                state_d = EXPAND;
            end
            EXPAND: if (idx_q == IDXW'(N_CLUSTERS - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready_o = (state_q == IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_q           <= '0;
            ovf_q             <= 1'b0;
            idx_q             <= '0;
            cnt_q             <= '0;
            map_q             <= '0;
            bus.sbits_o       <= '0;
            bus.sbits_valid_o <= 1'b0;
            bus.overflow_o    <= 1'b0;
            bus.n_clusters_o  <= '0;
        end else begin
            if (accept) begin
                frame_q <= bus.clusters_i;
                ovf_q   <= bus.overflow_i;
                map_q   <= '0;
                idx_q   <= '0;
                cnt_q   <= '0;
            end
            if (state_q == EXPAND) begin
                idx_q <= idx_q + IDXW'(1);
                if (slot_hit) begin
                    map_q <= map_q | mask;
                    cnt_q <= cnt_q + 4'd1;
                end
            end
            bus.sbits_valid_o <= (state_q == DONE);
            if (state_q == DONE) begin
                bus.sbits_o      <= map_q;
                bus.n_clusters_o <= cnt_q;
                bus.overflow_o   <= ovf_q;
            end
        end
    end

`ifdef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
    logic ovl_q;

    // Sticky per frame: any non-empty cluster landing on strips already set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovl_q         <= 1'b0;
            bus.overlap_o <= 1'b0;
        end else begin
            if (accept)
                ovl_q <= 1'b0;
            else if (state_q == EXPAND && slot_hit && |(mask & map_q))
                ovl_q <= 1'b1;
            if (state_q == DONE)
                bus.overlap_o <= ovl_q;
        end
    end
`else
    assign bus.overlap_o = 1'b0;
`endif

endmodule

// File: tb/tb_cluster_unpacker.sv
// Randomized scoreboard bench for cluster_unpacker: strip-level reference model,
// decoupled accept/monitor processes, directed corner frames and a mid-frame reset.
module tb_cluster_unpacker;
    localparam int NC  = 8;
    localparam int MXS = 1536;
    localparam int LAT = NC + 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    cluster_unpacker_if #(.N_CLUSTERS(NC), .CLW(14), .MXSBITS(MXS)) bus ();

    cluster_unpacker #(.N_CLUSTERS(NC), .MXADRB(11), .MXCNTB(3), .MXSBITS(MXS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [MXS-1:0] map;
        int             n;
        logic           ovf;
        logic           ovl;
        int             edge_n;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             n_checks  = 0;
    int             n_fail    = 0;
    int             cyc       = 0;
    int             last_acc  = -1;
    bit             cont_mode = 1'b0;
    logic [MXS-1:0] held      = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input string detail);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s %s", name, detail);
        end
    endtask

    function automatic string map_info(input logic [MXS-1:0] act, input logic [MXS-1:0] exp);
        return $sformatf("act_ones=%0d act_lo=%h exp_ones=%0d exp_lo=%h",
                         $countones(act), act[63:0], $countones(exp), exp[63:0]);
    endfunction

    // Reference: walk each non-empty cluster strip by strip.
    function automatic exp_t model(input logic [NC*14-1:0] fr, input logic ovf, input int e);
        exp_t r;
        int   adr, sz;
        r.map = '0; r.n = 0; r.ovf = ovf; r.ovl = 1'b0; r.edge_n = e;
        for (int k = 0; k < NC; k++) begin
            adr = int'(fr[14*k +: 11]);
            sz  = int'(fr[14*k+11 +: 3]) + 1;
            if (adr < MXS) begin
                r.n++;
                for (int s = adr; s < adr + sz && s < MXS; s++) begin
                    if (r.map[s]) r.ovl = 1'b1;
                    r.map[s] = 1'b1;
                end
            end
        end
`ifndef CLUSTER_UNPACKER_OVERLAP_CHECK_EN
        r.ovl = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [13:0] mk(input int cnt, input int adr);
        logic [2:0]  c;
        logic [10:0] a;
        c = 3'(cnt);
        a = 11'(adr);
        return {c, a};
    endfunction

    function automatic logic [NC*14-1:0] empty_frame();
        logic [NC*14-1:0] f;
        for (int k = 0; k < NC; k++) f[14*k +: 14] = mk(0, 'h7FF);
        return f;
    endfunction

    function automatic logic [NC*14-1:0] rand_frame();
        logic [NC*14-1:0] f;
        int               a;
        for (int k = 0; k < NC; k++) begin
            case ($urandom_range(0, 4))
                0:       a = int'($urandom_range(1536, 2047));
                1:       a = int'($urandom_range(1520, 1535));
                2:       a = int'($urandom_range(0, 31));
                default: a = int'($urandom_range(0, 1535));
            endcase
            f[14*k +: 14] = mk(int'($urandom_range(0, 7)), a);
        end
        return f;
    endfunction

    // Accept side: expected response is queued on every handshake.
    always @(posedge clock) begin
        if (!cont_mode) last_acc = -1;
        if (reset_n && bus.ready_o && bus.clusters_valid_i) begin
            sb.push_back(model(bus.clusters_i, bus.overflow_i, cyc));
            if (cont_mode && last_acc >= 0)
                chk("accept_spacing", (cyc - last_acc) == LAT,
                    $sformatf("act=%0d exp=%0d", cyc - last_acc, LAT));
            last_acc = cyc;
        end
    end

    // Monitor side: pop and compare on each output pulse, otherwise outputs must hold.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.sbits_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1'b0, "act=1 exp=0");
                end else begin
                    mon_e = sb.pop_front();
                    chk("sbits", bus.sbits_o === mon_e.map, map_info(bus.sbits_o, mon_e.map));
                    chk("n_clusters", bus.n_clusters_o === 4'(mon_e.n),
                        $sformatf("act=%0d exp=%0d", bus.n_clusters_o, mon_e.n));
                    chk("overflow", bus.overflow_o === mon_e.ovf,
                        $sformatf("act=%b exp=%b", bus.overflow_o, mon_e.ovf));
                    chk("overlap", bus.overlap_o === mon_e.ovl,
                        $sformatf("act=%b exp=%b", bus.overlap_o, mon_e.ovl));
                    chk("latency", (cyc - mon_e.edge_n) == LAT,
                        $sformatf("act=%0d exp=%0d", cyc - mon_e.edge_n, LAT));
                    held = mon_e.map;
                end
            end else begin
                chk("sbits_hold", bus.sbits_o === held, map_info(bus.sbits_o, held));
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_sbits"}, bus.sbits_o === '0, map_info(bus.sbits_o, '0));
        chk({tag, "_valid"}, bus.sbits_valid_o === 1'b0, $sformatf("act=%b exp=0", bus.sbits_valid_o));
        chk({tag, "_ovf"}, bus.overflow_o === 1'b0, $sformatf("act=%b exp=0", bus.overflow_o));
        chk({tag, "_n"}, bus.n_clusters_o === 4'd0, $sformatf("act=%0d exp=0", bus.n_clusters_o));
        chk({tag, "_ovl"}, bus.overlap_o === 1'b0, $sformatf("act=%b exp=0", bus.overlap_o));
    endtask

    // Waits (bounded) for IDLE, then presents the frame for exactly one cycle.
    task automatic send(input logic [NC*14-1:0] fr, input logic ovf);
        int t;
        t = 0;
        @(negedge clock);
        while (!bus.ready_o && t < 4 * LAT) begin
            @(negedge clock);
            t++;
        end
        if (!bus.ready_o) chk("ready_timeout", 1'b0, "act=0 exp=1");
        bus.clusters_i       = fr;
        bus.overflow_i       = ovf;
        bus.clusters_valid_i = 1'b1;
        @(negedge clock);
        bus.clusters_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 4 * LAT) begin
            @(negedge clock);
            t++;
        end
        chk("drain", sb.size() == 0, $sformatf("act_pending=%0d exp=0", sb.size()));
        repeat (2) @(negedge clock);
    endtask

    logic [NC*14-1:0] fr;

    initial begin
        bus.clusters_i       = '0;
        bus.clusters_valid_i = 1'b0;
        bus.overflow_i       = 1'b0;

        repeat (3) @(negedge clock);
        check_zero_outputs("in_reset");
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_ready", bus.ready_o === 1'b1, $sformatf("act=%b exp=1", bus.ready_o));
        check_zero_outputs("after_reset");

        fr = empty_frame(); fr[13:0] = mk(1, 2);
        send(fr, 1'b0);
        drain();

        for (int k = 0; k < NC; k++) fr[14*k +: 14] = mk(1, 192 * k);
        send(fr, 1'b1);
        drain();

        fr = empty_frame(); fr[13:0] = mk(7, 1533); fr[27:14] = mk(0, 'h7FE);
        send(fr, 1'b0);
        drain();

        fr = empty_frame(); fr[13:0] = mk(3, 10); fr[27:14] = mk(1, 12);
        send(fr, 1'b0);
        drain();
        fr[27:14] = mk(1, 14);
        send(fr, 1'b0);
        drain();

        fr = empty_frame(); fr[13:0] = mk(2, 40); fr[27:14] = mk(2, 40);
        send(fr, 1'b1);
        drain();

        // Back-to-back valid with fresh data every cycle.
        cont_mode = 1'b1;
        for (int i = 0; i < 6 * LAT; i++) begin
            @(negedge clock);
            bus.clusters_i       = rand_frame();
            bus.overflow_i       = 1'($urandom_range(0, 1));
            bus.clusters_valid_i = 1'b1;
        end
        @(negedge clock);
        bus.clusters_valid_i = 1'b0;
        cont_mode = 1'b0;
        drain();

        // Abort a frame in its 4th expand cycle.
        for (int k = 0; k < NC; k++) fr[14*k +: 14] = mk(7, 100 * k + 5);
        send(fr, 1'b1);
        repeat (3) @(negedge clock);
        #1 reset_n = 1'b0;
        sb.delete();
        held = '0;
        #1 check_zero_outputs("async_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rerelease_ready", bus.ready_o === 1'b1, $sformatf("act=%b exp=1", bus.ready_o));
        fr = empty_frame(); fr[27:14] = mk(4, 700);
        send(fr, 1'b0);
        drain();

        for (int i = 0; i < 30; i++) begin
            send(rand_frame(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 12)) @(negedge clock);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
